// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the slice-serial adder sequencer.
package rca_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

  // Slice index width, never narrower than one bit (WIDTH=8 has a single slice).
  function automatic int idx_w(input int width);
    return (nslice(width) > 1) ? $clog2(nslice(width)) : 1;
  endfunction

endpackage

// File: rtl/rca_word_sequencer_rca.sv
// RCA: the shared 8-bit ripple-carry adder built from a chain of full adders.
module RCA
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] Sum,
  output logic               Cout
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = Cin;

  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
      assign Sum[gi]    = A[gi] ^ B[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = w_c[SLICE_W];

endmodule

// File: rtl/rca_word_sequencer.sv
// Adds WIDTH-bit operands one 8-bit slice per cycle through a single RCA,
// LSB slice first, with the inter-slice carry held in a register.
module rca_word_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_busy;

  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic               w_last;

  assign w_slice_a = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_slice_b = r_b[SLICE_W*r_idx +: SLICE_W];
  assign w_last    = (r_idx == LAST_IDX);

  RCA u_rca (
    .A    (w_slice_a),
    .B    (w_slice_b),
    .Cin  (r_carry),
    .Sum  (w_slice_sum),
    .Cout (w_slice_cout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = ADD;
      ADD:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        ADD: begin
          r_sum[SLICE_W*r_idx +: SLICE_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          if (w_last) begin
            // Final slice: its sum MSB is the word MSB, so overflow is known now.
            r_cout <= w_slice_cout;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_slice_sum[SLICE_W-1] != r_a[WIDTH-1]);
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Drives a 32-bit and an 8-bit sequencer with shared handshakes and checks
// both against a plain-arithmetic reference add.
module tb_rca_word_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_cin = 1'b0;

  logic        in_ready32, out_valid32, cout32, ovf32, busy32;
  logic [31:0] sum32;
  logic        in_ready8, out_valid8, cout8, ovf8, busy8;
  logic [7:0]  sum8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rca_word_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .a(op_a), .b(op_b), .cin(op_cin), .out_valid(out_valid32),
    .out_ready(out_ready), .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32)
  );

  rca_word_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(op_a[7:0]), .b(op_b[7:0]), .cin(op_cin), .out_valid(out_valid8),
    .out_ready(out_ready), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} of a w-bit add done as ordinary integer arithmetic.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic        co;
    logic        ov;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, c};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on both DUTs: accept, measure latency, hold out_ready low
  // for 'hold' cycles, then release. With 'scramble', in_valid stays high and
  // operands change every cycle after the accept edge.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic c,
                     input int hold, input bit scramble);
    logic [33:0] e32, e8;
    int lat32, lat8;
    check("pre_in_ready32", {31'd0, in_ready32}, 32'd1);
    op_a = a; op_b = b; op_cin = c; in_valid = 1'b1;
    e32 = ref_add(32, a, b, c);
    e8  = ref_add(8, a, b, c);
    tick();
    if (!scramble) in_valid = 1'b0;
    lat32 = -1; lat8 = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid8 && lat8 < 0) lat8 = cyc;
      if (out_valid32 && lat32 < 0) lat32 = cyc;
      if (lat32 >= 0 && lat8 >= 0) break;
      if (cyc > 0) check("add_in_ready32", {31'd0, in_ready32}, 32'd0);
      if (scramble) begin op_a = $urandom; op_b = $urandom; op_cin = 1'($urandom); end
      tick();
    end
    check("latency32", lat32, 32'd4);
    check("latency8", lat8, 32'd1);
    for (int h = 0; h <= hold; h++) begin
      check("sum32", sum32, e32[31:0]);
      check("cout32", {31'd0, cout32}, {31'd0, e32[32]});
      check("ovf32", {31'd0, ovf32}, {31'd0, e32[33]});
      check("sum8", {24'd0, sum8}, e8[31:0]);
      check("cout8", {31'd0, cout8}, {31'd0, e8[32]});
      check("ovf8", {31'd0, ovf8}, {31'd0, e8[33]});
      check("done_valid", {30'd0, out_valid32, out_valid8}, 32'd3);
      check("done_busy", {30'd0, busy32, busy8}, 32'd3);
      check("done_in_ready", {30'd0, in_ready32, in_ready8}, 32'd0);
      if (h < hold) begin
        if (scramble) begin op_a = $urandom; op_b = $urandom; end
        tick();
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("rel_valid", {30'd0, out_valid32, out_valid8}, 32'd0);
    check("rel_in_ready", {30'd0, in_ready32, in_ready8}, 32'd3);
    check("rel_busy", {30'd0, busy32, busy8}, 32'd0);
    $display("txn a=%h b=%h cin=%0d sum32=%h cout32=%0d ovf32=%0d sum8=%h cout8=%0d ovf8=%0d",
             a, b, c, sum32, cout32, ovf32, sum8, cout8, ovf8);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", {30'd0, in_ready32, in_ready8}, 32'd3);
    check("rst_valid", {30'd0, out_valid32, out_valid8}, 32'd0);
    check("rst_busy", {30'd0, busy32, busy8}, 32'd0);
    check("rst_sum32", sum32, 32'd0);
    check("rst_flags", {28'd0, cout32, ovf32, cout8, ovf8}, 32'd0);

    run(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run(32'h12345678, 32'h11111111, 1'b1, 0, 1'b0);
    run(32'h000000FF, 32'h000000FF, 1'b1, 0, 1'b0);
    run(32'h80000000, 32'h80000000, 1'b0, 10, 1'b0);
    run(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 2, 1'b1);
    run(32'h00000042, 32'h00000017, 1'b0, 0, 1'b0);

    // Reset during the second ADD cycle discards the operation.
    op_a = 32'hDEADBEEF; op_b = 32'h01020304; op_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", {30'd0, in_ready32, in_ready8}, 32'd3);
    check("mid_rst_sum32", sum32, 32'd0);
    check("mid_rst_sum8", {24'd0, sum8}, 32'd0);
    check("mid_rst_busy", {30'd0, busy32, busy8}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("mid_rst_no_valid", {30'd0, out_valid32, out_valid8}, 32'd0);
      tick();
    end
    run(32'hDEADBEEF, 32'h01020304, 1'b1, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run(ra, rb, 1'($urandom), (i % 7 == 0) ? 2 : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
